dac_spi_tx: RTL and testbench
=============================

DAC_SPI_TX -- requirements
Module: dac_spi_tx

Interface
- REQ-001: Parameter SCK_HALF, default 2: number of clock cycles per dac_sck half-period; legal range 1..255.
- REQ-002: Parameter CS_GAP, default 2: minimum number of clock cycles dac_cs stays high between frames; legal range 1..255.
- REQ-003: clock  input  1  single system clock; all state changes on its rising edge.
- REQ-004: reset  input  1  asynchronous, active-high reset.
- REQ-005: in_valid  input  1  a sample is offered on in_cmd/in_addr/in_data.
- REQ-006: in_ready  output  1  the block accepts a sample this cycle.
- REQ-007: in_cmd  input  4  DAC command nibble.
- REQ-008: in_addr  input  4  DAC channel address nibble.
- REQ-009: in_data  input  12  unsigned sample value.
- REQ-010: dac_sck  output  1  SPI serial clock to the DAC.
- REQ-011: dac_cs  output  1  SPI chip select, active low.
- REQ-012: dac_clr  output  1  DAC asynchronous clear, active low.
- REQ-013: dac_mosi  output  1  SPI serial data to the DAC, MSB first.
- REQ-014: frame_done  output  1  one-cycle pulse at the end of each frame.

Function
- REQ-015: The state machine SHALL have exactly the states IDLE, SHIFT and GAP.
- REQ-016: in_ready SHALL be 1 only in IDLE; a transfer occurs on a rising edge where in_valid=1 and in_ready=1.
- REQ-017: On transfer, the block SHALL capture the 32-bit frame {8'h00, in_cmd, in_addr, in_data, 4'h0} and enter SHIFT on the same edge.
- REQ-018: On that same edge, dac_cs SHALL fall to 0, dac_mosi SHALL present frame bit 31 and dac_sck SHALL be 0.
- REQ-019: In SHIFT, dac_sck SHALL stay low for SCK_HALF cycles, then rise and stay high for SCK_HALF cycles, once per bit, for exactly 32 bits.
- REQ-020: dac_mosi SHALL change only on the edge where dac_sck falls (or on frame start), so it is stable for SCK_HALF cycles around every rising dac_sck.
- REQ-021: On the edge ending bit 0's high phase (64*SCK_HALF cycles after the transfer edge), the block SHALL drive dac_sck=0, dac_cs=1 and dac_mosi=0, pulse frame_done=1 for that one cycle, and enter GAP.
- REQ-022: GAP SHALL last CS_GAP cycles, then return to IDLE; in_ready SHALL first be 1 at 64*SCK_HALF+CS_GAP cycles after the transfer edge.
- REQ-023: in_valid, in_cmd, in_addr and in_data SHALL be ignored outside IDLE; captured frame content SHALL NOT change mid-frame.
- REQ-024: With in_valid held at 1, frames SHALL run back-to-back with a period of exactly 64*SCK_HALF+CS_GAP+1 cycles per transfer edge.
- REQ-025: All outputs SHALL come directly from registers (no combinational paths from inputs to outputs).
- REQ-026: The bit counter SHALL be 5 bits and the half-period counter 8 bits; neither SHALL wrap during a legal frame.

Reset
- REQ-027: While reset=1, outputs SHALL be: dac_cs=1, dac_sck=0, dac_mosi=0, dac_clr=0, in_ready=0, frame_done=0, state=IDLE.
- REQ-028: On the first rising clock edge after reset deasserts, dac_clr SHALL go to 1 and stay 1; in_ready SHALL go to 1 on that same edge.
- REQ-029: Reset asserted mid-frame SHALL force the REQ-027 values immediately (asynchronously), abandoning the frame with no frame_done pulse.

Verification
- REQ-030: Reset scenario: pulse reset for 6 ns with a 4 ns clock period -> REQ-027 values during reset; dac_clr=1 and in_ready=1 one edge after release.
- REQ-031: Single-frame scenario: SCK_HALF=2, offer cmd=4'h3, addr=4'h0, data=12'hABC -> dac_mosi sampled on the 32 rising edges of dac_sck reads 32'h0030ABC0, dac_cs is low for 128 cycles, frame_done pulses once.
- REQ-032: Back-to-back scenario: in_valid held at 1 with SCK_HALF=2 and CS_GAP=2 -> transfer edges are 131 cycles apart and dac_cs is high for at least 2 cycles between frames.
- REQ-033: Busy scenario: change in_data to 12'h555 and toggle in_valid during SHIFT -> in_ready=0 throughout and the frame still carries the originally captured value.
- REQ-034: Boundary scenario: send data=12'hFFF, then data=12'h000 on addr=4'hF -> frames read 32'h003FFFF0 and 32'h003F0000.
- REQ-035: Mid-frame reset scenario: assert reset at bit 16 -> dac_cs=1 and dac_sck=0 within the same time step with no frame_done pulse, and the next frame after release is complete and correct.

Source files
------------

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises one 32-bit DAC command frame per accepted sample over SPI.
// Frame layout {8'h00, cmd, addr, data, 4'h0}, MSB first; data changes on falling sck.
module dac_spi_tx #(
   parameter int unsigned SCK_HALF = 2,
   parameter int unsigned CS_GAP   = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_cmd,
   input  logic [3:0]  in_addr,
   input  logic [11:0] in_data,
   output logic        dac_sck,
   output logic        dac_cs,
   output logic        dac_clr,
   output logic        dac_mosi,
   output logic        frame_done
);

   localparam int unsigned FRAME_W = 32;
   localparam int unsigned BIT_W   = 5;
   localparam int unsigned HALF_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [FRAME_W-1:0]  shreg_q, shreg_d;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [HALF_W-1:0]   half_cnt_q, half_cnt_d;
   logic                sck_q, sck_d;
   logic                cs_q, cs_d;
   logic                mosi_q, mosi_d;
   logic                clr_q, clr_d;
   logic                ready_q, ready_d;
   logic                done_q, done_d;

   logic [FRAME_W-1:0]  frame_c;
   logic                xfer_c;
   logic                half_done_c;
   logic                gap_done_c;
   logic                last_bit_c;

   // Shared decode: frame image, handshake and counter terminal conditions
   always_comb begin
      frame_c     = {8'h00, in_cmd, in_addr, in_data, 4'h0};
      xfer_c      = in_valid && ready_q && (state_q == IDLE);
      half_done_c = (half_cnt_q == HALF_W'(SCK_HALF - 1));
      gap_done_c  = (half_cnt_q == HALF_W'(CS_GAP - 1));
      last_bit_c  = (bit_cnt_q == '0);
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (xfer_c) state_d = SHIFT;
         SHIFT:   if (half_done_c && sck_q && last_bit_c) state_d = GAP;
         GAP:     if (gap_done_c) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next values; the half counter doubles as the gap timer
   always_comb begin
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      half_cnt_d = half_cnt_q;
      sck_d      = sck_q;
      cs_d       = cs_q;
      mosi_d     = mosi_q;
      ready_d    = ready_q;
      done_d     = 1'b0;
      clr_d      = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (xfer_c) begin
               shreg_d    = {frame_c[FRAME_W-2:0], 1'b0};
               mosi_d     = frame_c[FRAME_W-1];
               bit_cnt_d  = BIT_W'(FRAME_W - 1);
               half_cnt_d = '0;
               sck_d      = 1'b0;
               cs_d       = 1'b0;
               ready_d    = 1'b0;
            end else begin
               ready_d = 1'b1;
            end
         end
         SHIFT: begin
            if (!half_done_c) begin
               half_cnt_d = half_cnt_q + HALF_W'(1);
            end else begin
               half_cnt_d = '0;
               if (!sck_q) begin
                  sck_d = 1'b1;
               end else if (last_bit_c) begin
                  sck_d  = 1'b0;
                  cs_d   = 1'b1;
                  mosi_d = 1'b0;
                  done_d = 1'b1;
               end else begin
                  sck_d     = 1'b0;
                  mosi_d    = shreg_q[FRAME_W-1];
                  shreg_d   = {shreg_q[FRAME_W-2:0], 1'b0};
                  bit_cnt_d = bit_cnt_q - BIT_W'(1);
               end
            end
         end
         GAP: begin
            if (gap_done_c) begin
               ready_d = 1'b1;
            end else begin
               half_cnt_d = half_cnt_q + HALF_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         half_cnt_q <= '0;
         sck_q      <= 1'b0;
         cs_q       <= 1'b1;
         mosi_q     <= 1'b0;
         clr_q      <= 1'b0;
         ready_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         half_cnt_q <= half_cnt_d;
         sck_q      <= sck_d;
         cs_q       <= cs_d;
         mosi_q     <= mosi_d;
         clr_q      <= clr_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
      end
   end

   assign in_ready   = ready_q;
   assign dac_sck    = sck_q;
   assign dac_cs     = cs_q;
   assign dac_clr    = clr_q;
   assign dac_mosi   = mosi_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: random and directed frames, scoreboard of expected frames,
// SPI monitor that reassembles MOSI on rising sck and checks frame timing.
module tb_dac_spi_tx;

   localparam int unsigned SCK_HALF  = 2;
   localparam int unsigned CS_GAP    = 2;
   localparam int unsigned FRAME_CYC = 64 * SCK_HALF;
   localparam int unsigned PERIOD    = FRAME_CYC + CS_GAP + 1;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_cmd;
   logic [3:0]  in_addr;
   logic [11:0] in_data;
   logic        dac_sck;
   logic        dac_cs;
   logic        dac_clr;
   logic        dac_mosi;
   logic        frame_done;

   dac_spi_tx #(.SCK_HALF(SCK_HALF), .CS_GAP(CS_GAP)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_cmd     (in_cmd),
      .in_addr    (in_addr),
      .in_data    (in_data),
      .dac_sck    (dac_sck),
      .dac_cs     (dac_cs),
      .dac_clr    (dac_clr),
      .dac_mosi   (dac_mosi),
      .frame_done (frame_done)
   );

   // 4-unit clock, posedges at 0, 4, 8, ...
   initial begin
      clock = 1'b1;
      forever #2 clock = ~clock;
   end

   int          n_chk = 0;
   int          n_pass = 0;
   logic [31:0] exp_q[$];
   int unsigned cyc = 0;
   int unsigned xfer_cyc = 0;

   // Reference frame: fields placed by weight, 8 zero MSBs and 4 zero LSBs
   function automatic logic [31:0] model(input logic [3:0] c, input logic [3:0] a,
                                         input logic [11:0] d);
      return (32'(c) * 32'h0010_0000) + (32'(a) * 32'h0001_0000) + (32'(d) * 32'h10);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Scoreboard push on every accepted sample
   always @(posedge clock) begin
      if (!reset && in_valid && in_ready) begin
         exp_q.push_back(model(in_cmd, in_addr, in_data));
         xfer_cyc = cyc;
      end
      cyc++;
   end

   // SPI monitor
   logic [31:0] acc = '0;
   int          mon_bits = 0;
   int          cs_low = 0;
   int          gap_hi = 0;
   int          done_cnt = 0;
   bit          sck_prev = 1'b0;
   bit          rdy_bad = 1'b0;
   bit          seen_frame = 1'b0;

   always @(negedge clock) begin
      if (reset) begin
         acc = '0; mon_bits = 0; cs_low = 0; gap_hi = 0;
         sck_prev = 1'b0; rdy_bad = 1'b0; seen_frame = 1'b0;
      end else begin
         if (!dac_cs) begin
            cs_low++;
            if (cs_low == 1) begin
               if (seen_frame) chk("cs_gap_min", 32'(gap_hi >= int'(CS_GAP)), 1);
               gap_hi = 0;
            end
            if (in_ready) rdy_bad = 1'b1;
            if (dac_sck && !sck_prev) begin
               acc = {acc[30:0], dac_mosi};
               mon_bits++;
            end
         end else begin
            gap_hi++;
         end
         sck_prev = dac_sck;
         if (frame_done) begin
            done_cnt++;
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else chk("frame_data", acc, exp_q.pop_front());
            chk("frame_bits", 32'(mon_bits), 32);
            chk("cs_low_cycles", 32'(cs_low), FRAME_CYC);
            chk("ready_low_in_frame", 32'(rdy_bad), 0);
            chk("end_lines", {29'd0, dac_cs, dac_sck, dac_mosi}, 32'h4);
            acc = '0; mon_bits = 0; cs_low = 0; rdy_bad = 1'b0;
            seen_frame = 1'b1;
         end
      end
   end

   // Offer one sample and wait for its transfer edge
   task automatic send(input logic [3:0] c, input logic [3:0] a, input logic [11:0] d,
                       output int unsigned at);
      bit rdy;
      at = 0;
      @(negedge clock);
      in_cmd = c; in_addr = a; in_data = d; in_valid = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         rdy = in_ready;
         @(posedge clock);
         if (rdy) begin
            #1;
            at = xfer_cyc;
            return;
         end
         @(negedge clock);
      end
      chk("send_timeout", 0, 1);
   endtask

   task automatic drop();
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         if (exp_q.size() == 0 && dac_cs && in_ready) return;
      end
      chk("idle_timeout", 0, 1);
   endtask

   int unsigned t0, t1;
   int          d0;

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_cmd = '0; in_addr = '0; in_data = '0;

      // Reset values while reset is held
      #3;
      chk("rst_cs",    32'(dac_cs), 1);
      chk("rst_sck",   32'(dac_sck), 0);
      chk("rst_mosi",  32'(dac_mosi), 0);
      chk("rst_clr",   32'(dac_clr), 0);
      chk("rst_ready", 32'(in_ready), 0);
      chk("rst_done",  32'(frame_done), 0);
      #3 reset = 1'b0;
      @(posedge clock); #1;
      chk("post_rst_clr",   32'(dac_clr), 1);
      chk("post_rst_ready", 32'(in_ready), 1);

      // Single frame
      d0 = done_cnt;
      send(4'h3, 4'h0, 12'hABC, t0); drop(); wait_idle();
      chk("single_done_once", 32'(done_cnt - d0), 1);

      // Boundary data values
      send(4'h3, 4'hF, 12'hFFF, t0); drop(); wait_idle();
      send(4'h3, 4'hF, 12'h000, t0); drop(); wait_idle();

      // Busy: inputs change while shifting must not leak into the frame
      send(4'h3, 4'h1, 12'h123, t0);
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         in_valid = 1'($urandom_range(0, 1));
         in_data  = 12'h555;
      end
      in_valid = 1'b0;
      wait_idle();

      // Randomised frames with random idle spacing
      for (int i = 0; i < 8; i++) begin
         send(4'($urandom), 4'($urandom), 12'($urandom), t0);
         drop();
         repeat ($urandom_range(0, 4)) @(negedge clock);
      end
      wait_idle();

      // Back-to-back with in_valid held high
      send(4'($urandom), 4'($urandom), 12'($urandom), t0);
      for (int i = 0; i < 3; i++) begin
         send(4'($urandom), 4'($urandom), 12'($urandom), t1);
         chk("b2b_period", t1 - t0, PERIOD);
         t0 = t1;
      end
      drop(); wait_idle();

      // Reset mid-frame at bit 16
      d0 = done_cnt;
      send(4'h5, 4'h2, 12'h9A5, t0); drop();
      for (int i = 0; i < 500 && mon_bits < 16; i++) @(negedge clock);
      chk("reached_bit16", 32'(mon_bits >= 16), 1);
      reset = 1'b1;
      #1;
      chk("midrst_cs",   32'(dac_cs), 1);
      chk("midrst_sck",  32'(dac_sck), 0);
      chk("midrst_mosi", 32'(dac_mosi), 0);
      chk("midrst_done", 32'(frame_done), 0);
      chk("midrst_clr",  32'(dac_clr), 0);
      exp_q.delete();
      repeat (3) @(negedge clock);
      chk("midrst_no_done", 32'(done_cnt - d0), 0);
      reset = 1'b0;
      @(posedge clock); #1;
      chk("rel_clr",   32'(dac_clr), 1);
      chk("rel_ready", 32'(in_ready), 1);
      send(4'($urandom), 4'($urandom), 12'($urandom), t0); drop(); wait_idle();
      send(4'h3, 4'h0, 12'hABC, t0); drop(); wait_idle();

      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
